hk_spi_responder: RTL and testbench

Housekeeping SPI responder sitting directly behind the SDO/SDI/CSB/SCK pads (mprj[1:4]). It oversamples the external SPI mode-0 bus in the core clock domain and converts framed command/address/data bytes into single-cycle register read/write strobes on an internal register bus. It also generates the 3-bit DM code that sets the SDO pad direction.

---
 rtl/hk_spi_pkg.sv | 18 +
 rtl/hk_spi_sync.sv | 21 ++
 rtl/hk_spi_responder.sv | 183 ++++++++++++++++++
 tb/tb_hk_spi_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hk_spi_pkg.sv
// Shared types and constants for the housekeeping SPI responder.
package hk_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DATA   = 3'd3,
      ST_IGNORE = 3'd4
   } hk_state_e;

   localparam int CMD_WR_BIT = 7;
   localparam int CMD_RD_BIT = 6;

   localparam logic [2:0] DM_IN_NOPULL = 3'b001;
   localparam logic [2:0] DM_OUT       = 3'b110;

endpackage

// File: rtl/hk_spi_sync.sv
// N-flop synchronizer for one asynchronous pad input; the reset value is selectable.
module hk_spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) sync_q <= {STAGES{RST_VAL}};
      else          sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hk_spi_responder.sv
// Housekeeping SPI mode-0 responder: oversampled pads -> register read/write strobes.
// Define HKSPI_AUTOINC_EN to advance the address after each data byte; otherwise it is fixed per frame.
module hk_spi_responder
   import hk_spi_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              spi_csb_i,
   input  logic              spi_sck_i,
   input  logic              spi_sdi_i,
   output logic              spi_sdo_o,
   output logic [2:0]        sdo_dm_o,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [7:0]        reg_wdata_o,
   output logic              reg_we_o,
   output logic              reg_re_o,
   input  logic [7:0]        reg_rdata_i,
   output logic              busy_o
);

   logic csb_s, sck_s, sdi_s;

   hk_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d_i(spi_csb_i), .q_o(csb_s));
   hk_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d_i(spi_sck_i), .q_o(sck_s));
   hk_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d_i(spi_sdi_i), .q_o(sdi_s));

   logic                 csb_prev_q, sck_prev_q, armed_q;
   logic [SYNC_STAGES:0] settle_q;
   hk_state_e            state_q, state_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0]    addr_q, addr_d, addr_next;
   logic                 we_q, we_d, re_q, re_d, ld_q, ld_d, adv_q, adv_d;
   logic                 wr_q, wr_d, rd_q, rd_d;

   logic       sck_rise, sck_fall, csb_rise, csb_fall, byte_done;
   logic [7:0] rx_byte;

   assign sck_rise  = sck_s & ~sck_prev_q;
   assign sck_fall  = ~sck_s & sck_prev_q;
   assign csb_rise  = csb_s & ~csb_prev_q;
   assign csb_fall  = ~csb_s & csb_prev_q;
   assign rx_byte   = {rx_q[6:0], sdi_s};
   assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

`ifdef HKSPI_AUTOINC_EN
   assign addr_next = addr_q + 1'b1;
`else
   assign addr_next = addr_q;
`endif

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      adv_d     = 1'b0;
      ld_d      = re_q;

      // Read data arrives the cycle after the strobe; the MSB then waits for the next rise.
      if (ld_q) tx_d = reg_rdata_i;
      else if (sck_fall && bit_cnt_q != 3'd0 && state_q != ST_IDLE) tx_d = {tx_q[6:0], 1'b0};

      // A write of the current address must retire before the address moves on.
      if (adv_q) begin
         addr_d = addr_next;
         re_d   = rd_q;
      end

      if (sck_rise && state_q != ST_IDLE) begin
         rx_d      = rx_byte;
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (csb_fall && armed_q) state_d = ST_CMD;
         end
         ST_CMD: begin
            if (byte_done) begin
               wr_d    = rx_byte[CMD_WR_BIT];
               rd_d    = rx_byte[CMD_RD_BIT];
               state_d = (rx_byte[CMD_WR_BIT] || rx_byte[CMD_RD_BIT]) ? ST_ADDR : ST_IGNORE;
            end
         end
         ST_ADDR: begin
            if (byte_done) begin
               addr_d  = ADDR_W'(rx_byte);
               re_d    = rd_q;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (byte_done) begin
               if (wr_q) begin
                  we_d    = 1'b1;
                  wdata_d = rx_byte;
                  adv_d   = 1'b1;
               end else begin
                  addr_d = addr_next;
                  re_d   = 1'b1;
               end
            end
         end
         default: ;
      endcase

      if (csb_rise) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         rx_d      = 8'h00;
         tx_d      = 8'h00;
         wr_d      = 1'b0;
         rd_d      = 1'b0;
         we_d      = 1'b0;
         re_d      = 1'b0;
         adv_d     = 1'b0;
         ld_d      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         csb_prev_q <= 1'b1;
         sck_prev_q <= 1'b0;
         settle_q   <= '0;
         armed_q    <= 1'b0;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         rx_q       <= 8'h00;
         tx_q       <= 8'h00;
         addr_q     <= '0;
         wdata_q    <= 8'h00;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         ld_q       <= 1'b0;
         adv_q      <= 1'b0;
      end else begin
         csb_prev_q <= csb_s;
         sck_prev_q <= sck_s;
         settle_q   <= {settle_q[SYNC_STAGES-1:0], 1'b1};
         // Only a CSB seen high after the synchronizers refill can start a frame.
         if (settle_q[SYNC_STAGES] && csb_s) armed_q <= 1'b1;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         we_q       <= we_d;
         re_q       <= re_d;
         ld_q       <= ld_d;
         adv_q      <= adv_d;
      end
   end

   assign spi_sdo_o   = tx_q[7];
   assign sdo_dm_o    = (state_q != ST_IDLE && !csb_s) ? DM_OUT : DM_IN_NOPULL;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign reg_we_o    = we_q;
   assign reg_re_o    = re_q;
   assign busy_o      = ~csb_s;

endmodule

// File: tb/tb_hk_spi_responder.sv
// Self-checking bench for hk_spi_responder: directed and random SPI frames against a frame-level model.
module tb_hk_spi_responder;

`ifdef HKSPI_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       csb, sck, sdi;
   logic       sdo;
   logic [2:0] dm;
   logic [7:0] addr, wdata, rdata;
   logic       we, re, busy;

   always #5 clk = ~clk;

   hk_spi_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .spi_csb_i  (csb),
      .spi_sck_i  (sck),
      .spi_sdi_i  (sdi),
      .spi_sdo_o  (sdo),
      .sdo_dm_o   (dm),
      .reg_addr_o (addr),
      .reg_wdata_o(wdata),
      .reg_we_o   (we),
      .reg_re_o   (re),
      .reg_rdata_i(rdata),
      .busy_o     (busy)
   );

   // Register file side: read data is a fixed function of the address.
   assign rdata = addr ^ 8'hFF;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        wr_log[$];
   int         re_cnt;
   int         both_cnt;
   logic [7:0] tx_bytes[$];
   logic [7:0] rx_bytes[$];
   int         checks;
   int         failures;

   always @(negedge clk) begin
      if (!rst) begin
         if (we) wr_log.push_back('{a: addr, d: wdata});
         if (re) re_cnt++;
         if (we && re) both_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] got);
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sdi = b[7-i];
         wait_clk(6);
         got = {got[6:0], sdo};
         sck = 1'b1;
         wait_clk(6);
         sck = 1'b0;
      end
   endtask

   task automatic clear_logs();
      wr_log.delete();
      rx_bytes.delete();
      re_cnt = 0;
   endtask

   task automatic run_frame(input string tag, input int abort_bits);
      logic [7:0] g;
      clear_logs();
      csb = 1'b0;
      wait_clk(8);
      foreach (tx_bytes[i]) begin
         spi_byte(tx_bytes[i], 8, g);
         rx_bytes.push_back(g);
         check({tag, "_dm_sel"}, 32'(dm), 32'(3'b110));
      end
      if (abort_bits > 0) spi_byte(8'h5A, abort_bits, g);
      wait_clk(8);
      csb = 1'b1;
      wait_clk(8);
      check({tag, "_dm_idle"}, 32'(dm), 32'(3'b001));
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   // Frame-level reference: expectations derived from command, start address and byte count.
   task automatic check_frame(input string tag);
      logic [7:0] cmd, a0, a;
      int         n;
      bit         wr, rd;
      cmd = tx_bytes[0];
      a0  = tx_bytes[1];
      n   = tx_bytes.size() - 2;
      wr  = cmd[7];
      rd  = cmd[6];
      check({tag, "_wcount"}, 32'(wr_log.size()), wr ? 32'(n) : 32'd0);
      check({tag, "_recount"}, 32'(re_cnt), rd ? 32'(n + 1) : 32'd0);
      check({tag, "_sdo_cmd"}, 32'(rx_bytes[0]), 32'd0);
      check({tag, "_sdo_addr"}, 32'(rx_bytes[1]), 32'd0);
      for (int i = 0; i < n; i++) begin
         a = AUTOINC ? 8'((int'(a0) + i) % 256) : a0;
         if (wr && i < wr_log.size()) begin
            check({tag, $sformatf("_waddr%0d", i)}, 32'(wr_log[i].a), 32'(a));
            check({tag, $sformatf("_wdata%0d", i)}, 32'(wr_log[i].d), 32'(tx_bytes[i+2]));
         end
         check({tag, $sformatf("_sdo%0d", i)}, 32'(rx_bytes[i+2]), rd ? 32'(a ^ 8'hFF) : 32'd0);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired before the summary line");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] g;
      int         n, sel, abort;
      logic [7:0] cmd;
      checks   = 0;
      failures = 0;
      both_cnt = 0;
      re_cnt   = 0;
      rst = 1'b1;
      csb = 1'b1;
      sck = 1'b0;
      sdi = 1'b0;
      wait_clk(3);
      check("rst_sdo", 32'(sdo), 32'd0);
      check("rst_dm", 32'(dm), 32'(3'b001));
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_re", 32'(re), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_clk(10);

      tx_bytes = '{8'h80, 8'h10, 8'hA5, 8'h3C};
      run_frame("wr", 0);
      check_frame("wr");

      tx_bytes = '{8'h40, 8'hFE, 8'h00, 8'h00, 8'h00};
      run_frame("rd_wrap", 0);
      check_frame("rd_wrap");

      tx_bytes = '{8'h80, 8'h33, 8'h77};
      run_frame("abort", 5);
      check_frame("abort");

      tx_bytes = '{8'h00, 8'hAB, 8'hCD};
      run_frame("ignore", 0);
      check_frame("ignore");

      tx_bytes = '{8'hC0, 8'h7F, 8'($urandom), 8'($urandom), 8'($urandom)};
      run_frame("rdwr", 0);
      check_frame("rdwr");

      // Reset in the middle of a data byte with CSB held low.
      clear_logs();
      csb = 1'b0;
      wait_clk(8);
      spi_byte(8'h80, 8, g);
      spi_byte(8'h44, 8, g);
      spi_byte(8'h99, 4, g);
      rst = 1'b1;
      wait_clk(2);
      check("midrst_sdo", 32'(sdo), 32'd0);
      check("midrst_dm", 32'(dm), 32'(3'b001));
      check("midrst_addr", 32'(addr), 32'd0);
      check("midrst_wdata", 32'(wdata), 32'd0);
      check("midrst_we", 32'(we), 32'd0);
      check("midrst_re", 32'(re), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_clk(10);
      spi_byte(8'h12, 8, g);
      spi_byte(8'h34, 8, g);
      wait_clk(8);
      check("midrst_no_we", 32'(wr_log.size()), 32'd0);
      check("midrst_no_re", 32'(re_cnt), 32'd0);
      check("midrst_dm_low", 32'(dm), 32'(3'b001));
      csb = 1'b1;
      wait_clk(10);

      tx_bytes = '{8'h80, 8'h20, 8'h11, 8'h22, 8'h33};
      run_frame("fifo", 0);
      check_frame("fifo");

      for (int k = 0; k < 8; k++) begin
         sel = int'($urandom_range(0, 4));
         case (sel)
            0:       cmd = 8'h80;
            1:       cmd = 8'h40;
            2:       cmd = 8'hC0;
            3:       cmd = 8'h00;
            default: cmd = 8'($urandom);
         endcase
         n = int'($urandom_range(0, 3));
         tx_bytes.delete();
         tx_bytes.push_back(cmd);
         tx_bytes.push_back(8'($urandom));
         for (int j = 0; j < n; j++) tx_bytes.push_back(8'($urandom));
         abort = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
         run_frame($sformatf("rnd%0d", k), abort);
         check_frame($sformatf("rnd%0d", k));
      end

      check("we_re_overlap", 32'(both_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
